// File: rtl/img_mem_arbiter.sv
// Arbiter sharing the image-cache CPU-side port between the CPU load/store path
// and the UART loader/dumper; one transaction at a time with round-robin ties.
module img_mem_arbiter #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rd_ready,
  output logic              cpu_wr_ready,
  input  logic              uart_re,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_rd_ready,
  output logic              uart_wr_ready,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rd_ready,
  input  logic              mem_wr_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state_reg, state_next;

  // Requester 0 is the CPU, requester 1 is the UART.
  logic [1:0]        req_re, req_we, pend;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];

  logic              owner_reg, last_owner_reg, op_wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [1:0]        grant_reg;
  logic              busy_reg, mem_re_reg, mem_we_reg, timeout_err_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              win, do_grant, complete, abort, finish, hit;
  logic [1:0]        rd_ready_vec, wr_ready_vec;
  logic [DATA_W-1:0] rdata_vec [2];

  assign req_re       = {uart_re, cpu_re};
  assign req_we       = {uart_we, cpu_we};
  assign req_addr[0]  = cpu_addr;
  assign req_addr[1]  = uart_addr;
  assign req_wdata[0] = cpu_wdata;
  assign req_wdata[1] = uart_wdata;

  // Only the ready matching the issued operation ends the wait.
  assign hit    = op_wr_reg ? mem_wr_ready : mem_rd_ready;
  assign finish = complete | abort;

  always_comb begin
    state_next = state_reg;
    win        = 1'b0;
    do_grant   = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|pend) begin
          do_grant   = 1'b1;
          state_next = ISSUE;
          win        = (pend == 2'b11) ? ~last_owner_reg : pend[1];
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (hit) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_owner_reg  <= 1'b1;
      op_wr_reg       <= 1'b0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      grant_reg       <= 2'b00;
      busy_reg        <= 1'b0;
      mem_re_reg      <= 1'b0;
      mem_we_reg      <= 1'b0;
      timeout_err_reg <= 1'b0;
      cnt_reg         <= '0;
    end else begin
      state_reg <= state_next;
      if (do_grant) begin
        owner_reg  <= win;
        op_wr_reg  <= req_we[win];
        addr_reg   <= req_addr[win];
        wdata_reg  <= req_wdata[win];
        mem_re_reg <= ~req_we[win];
        mem_we_reg <= req_we[win];
        grant_reg  <= win ? 2'b10 : 2'b01;
        busy_reg   <= 1'b1;
        cnt_reg    <= '0;
      end
      if (state_reg == WAIT && !finish) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (finish) begin
        mem_re_reg     <= 1'b0;
        mem_we_reg     <= 1'b0;
        last_owner_reg <= owner_reg;
        cnt_reg        <= '0;
      end
      if (abort) begin
        timeout_err_reg <= 1'b1;
      end
      if (state_reg == DONE) begin
        grant_reg <= 2'b00;
        busy_reg  <= 1'b0;
      end
    end
  end

  // Per-requester completion pulses and held read data; aborted reads return 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic              rd_ready_reg, wr_ready_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mine;

    assign pend[gi] = req_re[gi] | req_we[gi];
    assign mine     = finish && (owner_reg == 1'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ready_reg <= 1'b0;
        wr_ready_reg <= 1'b0;
        rdata_reg    <= '0;
      end else begin
        rd_ready_reg <= mine && !op_wr_reg;
        wr_ready_reg <= mine && op_wr_reg;
        if (mine && !op_wr_reg) begin
          rdata_reg <= abort ? '0 : mem_rdata;
        end
      end
    end

    assign rd_ready_vec[gi] = rd_ready_reg;
    assign wr_ready_vec[gi] = wr_ready_reg;
    assign rdata_vec[gi]    = rdata_reg;
  end

  assign cpu_rd_ready  = rd_ready_vec[0];
  assign cpu_wr_ready  = wr_ready_vec[0];
  assign cpu_rdata     = rdata_vec[0];
  assign uart_rd_ready = rd_ready_vec[1];
  assign uart_wr_ready = wr_ready_vec[1];
  assign uart_rdata    = rdata_vec[1];

  assign mem_re      = mem_re_reg;
  assign mem_we      = mem_we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign grant       = grant_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter: a cache responder with programmable
// ready delay, a monitor logging grants/writes/ready pulses, and fixed expectations.
module tb_img_mem_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  logic              clk, rst;
  logic              cpu_re, cpu_we, uart_re, uart_we;
  logic [ADDR_W-1:0] cpu_addr, uart_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, uart_wdata, cpu_rdata, uart_rdata;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              cpu_rd_ready, cpu_wr_ready, uart_rd_ready, uart_wr_ready;
  logic              mem_re, mem_we, mem_rd_ready, mem_wr_ready;
  logic [1:0]        grant;
  logic              busy, timeout_err;

  img_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rd_ready(cpu_rd_ready), .cpu_wr_ready(cpu_wr_ready),
    .uart_re(uart_re), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .uart_rd_ready(uart_rd_ready), .uart_wr_ready(uart_wr_ready),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rd_ready(mem_rd_ready), .mem_wr_ready(mem_wr_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Cache model: ready after resp_delay enable cycles, data = addr[7:0] ^ resp_xor.
  int         resp_delay = 2;
  bit         resp_on    = 1'b1;
  bit         man_wr     = 1'b0;
  logic [7:0] resp_xor   = 8'h5A;
  int         en_cnt     = 0;

  initial begin
    mem_rd_ready = 1'b0;
    mem_wr_ready = 1'b0;
    mem_rdata    = '0;
  end

  always @(negedge clk) begin
    #1;
    if (mem_re || mem_we) en_cnt++;
    else en_cnt = 0;
    mem_rd_ready = resp_on && mem_re && (en_cnt == resp_delay);
    mem_wr_ready = (resp_on && mem_we && (en_cnt == resp_delay)) || man_wr;
    mem_rdata    = mem_addr[7:0] ^ resp_xor;
  end

  // Monitor, sampled shortly after each rising edge.
  int                n_cpu_rd = 0, n_cpu_wr = 0, n_uart_rd = 0, n_uart_wr = 0;
  int                re_cycles = 0, bad_ready = 0;
  logic [ADDR_W-1:0] last_re_addr = '0;
  logic [7:0]        wr_log[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [1:0]        grant_log[$];
  logic              prev_we = 1'b0;
  logic [1:0]        prev_grant = 2'b00;

  always @(posedge clk) begin
    #2;
    if (mem_re) begin
      re_cycles++;
      last_re_addr = mem_addr;
    end
    if (mem_we && !prev_we) begin
      wr_log.push_back(mem_wdata);
      wr_addr_log.push_back(mem_addr);
    end
    prev_we = mem_we;
    if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
    prev_grant = grant;
    if (cpu_rd_ready)  begin n_cpu_rd++;  $display("txn cpu  rd data=%02h", cpu_rdata);  end
    if (cpu_wr_ready)  begin n_cpu_wr++;  $display("txn cpu  wr done"); end
    if (uart_rd_ready) begin n_uart_rd++; $display("txn uart rd data=%02h", uart_rdata); end
    if (uart_wr_ready) begin n_uart_wr++; $display("txn uart wr done"); end
    if ((cpu_rd_ready || cpu_wr_ready) && grant != 2'b01) bad_ready++;
    if ((uart_rd_ready || uart_wr_ready) && grant != 2'b10) bad_ready++;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cpu_rd = 0; n_cpu_wr = 0; n_uart_rd = 0; n_uart_wr = 0;
    re_cycles = 0;
    wr_log.delete(); wr_addr_log.delete(); grant_log.delete();
  endtask

  // which: 0 cpu_rd, 1 cpu_wr, 2 uart_rd, 3 uart_wr; cycles = negedges waited.
  task automatic wait_ready(input int which, input string tag, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      cycles++;
      case (which)
        0:       got = cpu_rd_ready;
        1:       got = cpu_wr_ready;
        2:       got = uart_rd_ready;
        default: got = uart_wr_ready;
      endcase
    end
    if (!got) check({tag, "_no_ready"}, 32'd0, 32'd1);
  endtask

  int         lat;
  logic [15:0] seq;

  initial begin
    rst = 1'b0;
    cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    uart_re = 0; uart_we = 0; uart_addr = '0; uart_wdata = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_uart_rdata", 32'(uart_rdata), 32'd0);

    // Single CPU read, ready on the third WAIT cycle
    resp_delay = 4; resp_xor = 8'hB5;
    cpu_addr = 19'h00010; cpu_re = 1'b1;
    wait_ready(0, "t1", lat);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_re = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_re_cycles", 32'(re_cycles), 32'd4);
    check("t1_mem_addr", 32'(last_re_addr), 32'h00010);
    check("t1_cpu_rd_cnt", 32'(n_cpu_rd), 32'd1);
    check("t1_uart_ready_cnt", 32'(n_uart_rd + n_uart_wr), 32'd0);
    check("t1_grant_idle", 32'(grant), 32'd0);

    // Latency with immediate ready, then next grant to the pending UART
    do_reset();
    resp_delay = 2; resp_xor = 8'h5A;
    cpu_addr = 19'h00020; uart_addr = 19'h70003;
    cpu_re = 1'b1; uart_re = 1'b1;
    wait_ready(0, "lat", lat);
    check("lat_cpu_ready", 32'(lat), 32'd3);
    cpu_re = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && grant != 2'b10; i++) begin
      @(negedge clk);
      lat++;
    end
    check("lat_next_grant", 32'(lat), 32'd2);
    wait_ready(2, "lat_uart", lat);
    check("lat_uart_rdata", 32'(uart_rdata), 32'h59);
    uart_re = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous writes after reset: CPU first
    do_reset();
    cpu_addr = 19'h00001; cpu_wdata = 8'h11; cpu_we = 1'b1;
    uart_addr = 19'h40000; uart_wdata = 8'h22; uart_we = 1'b1;
    wait_ready(1, "sim_cpu", lat);
    cpu_we = 1'b0;
    wait_ready(3, "sim_uart", lat);
    uart_we = 1'b0;
    repeat (2) @(negedge clk);
    check("sim_wr_count", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() >= 2) begin
      check("sim_wdata0", 32'(wr_log[0]), 32'h11);
      check("sim_wdata1", 32'(wr_log[1]), 32'h22);
      check("sim_waddr0", 32'(wr_addr_log[0]), 32'h00001);
      check("sim_waddr1", 32'(wr_addr_log[1]), 32'h40000);
      check("sim_grant_seq", {28'd0, grant_log[0], grant_log[1]}, 32'b0110);
    end

    // Round-robin fairness over 8 reads
    do_reset();
    cpu_addr = 19'h00110; uart_addr = 19'h00233;
    cpu_re = 1'b1; uart_re = 1'b1;
    for (int i = 0; i < 200 && (n_cpu_rd + n_uart_rd) < 8; i++) @(negedge clk);
    cpu_re = 1'b0; uart_re = 1'b0;
    repeat (3) @(negedge clk);
    check("rr_grant_count", 32'(grant_log.size()), 32'd8);
    seq = '0;
    for (int i = 0; i < 8 && i < grant_log.size(); i++) seq = {seq[13:0], grant_log[i]};
    check("rr_grant_seq", 32'(seq), 32'h6666);
    check("rr_cpu_rd_cnt", 32'(n_cpu_rd), 32'd4);
    check("rr_uart_rd_cnt", 32'(n_uart_rd), 32'd4);
    check("rr_cpu_rdata", 32'(cpu_rdata), 32'h4A);
    check("rr_uart_rdata", 32'(uart_rdata), 32'h69);

    // Write wins over read on the same requester
    do_reset();
    cpu_addr = 19'h00005; cpu_wdata = 8'h77;
    cpu_re = 1'b1; cpu_we = 1'b1;
    wait_ready(1, "wp_wr", lat);
    check("wp_no_read_issued", 32'(re_cycles), 32'd0);
    cpu_we = 1'b0;
    wait_ready(0, "wp_rd", lat);
    check("wp_rdata", 32'(cpu_rdata), 32'h5F);
    cpu_re = 1'b0;
    repeat (2) @(negedge clk);
    check("wp_wdata", wr_log.size() > 0 ? 32'(wr_log[0]) : 32'hFFFF, 32'h77);
    check("wp_cpu_wr_cnt", 32'(n_cpu_wr), 32'd1);

    // Timeout: a good read first, then a read the cache never answers
    do_reset();
    uart_addr = 19'h00012; uart_re = 1'b1;
    wait_ready(2, "to_pre", lat);
    check("to_pre_rdata", 32'(uart_rdata), 32'h48);
    uart_re = 1'b0;
    @(negedge clk);
    resp_on = 1'b0; re_cycles = 0;
    uart_addr = 19'h00013; uart_re = 1'b1;
    wait_ready(2, "to", lat);
    check("to_rdata_zero", 32'(uart_rdata), 32'd0);
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_re_cycles", 32'(re_cycles), 32'd16);
    check("to_enable_dropped", 32'(mem_re), 32'd0);
    uart_re = 1'b0;
    @(negedge clk);
    resp_on = 1'b1;
    cpu_addr = 19'h00009; cpu_wdata = 8'h33; cpu_we = 1'b1;
    wait_ready(1, "to_next", lat);
    cpu_we = 1'b0;
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_next_wdata", wr_log.size() > 0 ? 32'(wr_log[wr_log.size()-1]) : 32'hFFFF, 32'h33);
    repeat (2) @(negedge clk);

    // Reset in the middle of a UART write
    n_uart_wr = 0;
    resp_on = 1'b0;
    uart_addr = 19'h00020; uart_wdata = 8'h44; uart_we = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_we_active", 32'(mem_we), 32'd1);
    rst = 1'b1; uart_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mr_mem_we", 32'(mem_we), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_grant", 32'(grant), 32'd0);
    check("mr_err_cleared", 32'(timeout_err), 32'd0);
    man_wr = 1'b1;
    @(negedge clk);
    man_wr = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_no_uart_wr_ready", 32'(n_uart_wr), 32'd0);
    check("mr_idle_busy", 32'(busy), 32'd0);
    check("mr_idle_mem_we", 32'(mem_we), 32'd0);

    check("non_owner_ready", 32'(bad_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
